botao_debounce: RTL and testbench

BOTAO_DEBOUNCE -- requirements
Module: botao_debounce

---
 rtl/botao_pkg.sv | 20 ++
 rtl/botao_canal.sv | 128 ++++++++++++
 rtl/botao_debounce.sv | 81 ++++++++
 tb/tb_botao_debounce.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/botao_pkg.sv
// -----------------------------------------------------------------------------
// botao_pkg
// Shared definitions for the two-button debouncer:
//   - deb_state_e         : per-channel debounce FSM state encoding
//   - DEBOUNCE_CYCLES_DEF : default number of stable synchronized samples (N)
//   - CNT_W_DEF           : default debounce counter width
// -----------------------------------------------------------------------------
package botao_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
    localparam int unsigned CNT_W_DEF           = 16;

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } deb_state_e;

endpackage : botao_pkg

// File: rtl/botao_canal.sv
// -----------------------------------------------------------------------------
// botao_canal
// One debounce channel: two-flop synchronizer, debounce FSM with saturating
// counter, registered clean level and one-cycle press pulse.
//
// Parameters
//   DEBOUNCE_CYCLES : stable synchronized samples N needed to accept a change
//   CNT_W           : debounce counter width
// Ports
//   clk     in  rising-edge clock
//   rst_n   in  asynchronous active-low reset
//   raw_i   in  raw contact, asynchronous to clk, may bounce
//   clean_o out debounced level
//   press_o out one-cycle pulse after the clean level rises
// -----------------------------------------------------------------------------
module botao_canal
    import botao_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic clean_o,
    output logic press_o
);

    // The sample that moves the FSM out of a stable state is the first of the
    // N target samples, so the WAIT state only has to see N-1 more. The
    // counter holds how many of those extra samples were already seen, so the
    // accepting sample arrives while it reads N-2.
    localparam logic [CNT_W-1:0] ACCEPT_CNT = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > 65535) ||
        ((longint'(1) << CNT_W) <= longint'(DEBOUNCE_CYCLES))) begin : g_bad_cfg
        $error("botao_canal: DEBOUNCE_CYCLES out of range or CNT_W too narrow");
    end

    logic [1:0]       sync_q;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             clean_q, clean_d;
    logic             press_q, press_d;
    logic             sample;

    assign sample = sync_q[1];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (the synchronizer chain
    // relies on this to really be two stages).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            state_q <= ST_LOW;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            press_q <= press_d;
        end
    end

    // Saturating increment: the counter can never wrap back to a low value.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        press_d = 1'b0;
        unique case (state_q)
            ST_LOW: begin
                if (sample) begin
                    state_d = ST_WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_HIGH: begin
                if (!sample) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q >= ACCEPT_CNT) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    clean_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_HIGH: begin
                if (!sample) begin
                    state_d = ST_WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_LOW: begin
                if (sample) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q >= ACCEPT_CNT) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                    clean_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
                clean_d = 1'b0;
            end
        endcase
    end

    assign clean_o = clean_q;
    assign press_o = press_q;

endmodule : botao_canal

// File: rtl/botao_debounce.sv
// -----------------------------------------------------------------------------
// botao_debounce
// Two independent push-button debouncers plus a registered LED driver.
//
// Parameters
//   DEBOUNCE_CYCLES : stable synchronized samples N (2..65535)
//   CNT_W           : debounce counter width (2**CNT_W > DEBOUNCE_CYCLES)
// Ports
//   clk       in  rising-edge clock
//   rst_n     in  asynchronous active-low reset
//   pino2_raw in  button 1 contact (asynchronous, bouncing)
//   pino3_raw in  button 2 contact (asynchronous, bouncing)
//   pino2     out debounced button 1 level
//   pino3     out debounced button 2 level
//   press2    out one-cycle pulse on accepted button 1 press
//   press3    out one-cycle pulse on accepted button 2 press
//   pino13    out registered LED drive
// Build option
//   BOTAO_DEBOUNCE_TOGGLE_EN : when defined, pino13 toggles once per cycle in
//   which any press pulse is high; otherwise pino13 is the registered OR of
//   the two clean levels.
// -----------------------------------------------------------------------------
module botao_debounce
    import botao_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pino2_raw,
    input  logic pino3_raw,
    output logic pino2,
    output logic pino3,
    output logic press2,
    output logic press3,
    output logic pino13
);

    logic led_q, led_d;

    botao_canal #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_canal2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (pino2_raw),
        .clean_o(pino2),
        .press_o(press2)
    );

    botao_canal #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_canal3 (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (pino3_raw),
        .clean_o(pino3),
        .press_o(press3)
    );

`ifdef BOTAO_DEBOUNCE_TOGGLE_EN
    // Press pulses on both channels in the same cycle count as one toggle.
    assign led_d = led_q ^ (press2 | press3);
`else
    assign led_d = pino2 | pino3;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= 1'b0;
        end else begin
            led_q <= led_d;
        end
    end

    assign pino13 = led_q;

endmodule : botao_debounce

// File: tb/tb_botao_debounce.sv
// -----------------------------------------------------------------------------
// tb_botao_debounce
// Directed self-checking bench for botao_debounce with N = 4. Inputs change on
// the falling edge; outputs are sampled 1 time unit after the rising edge.
// "Edge 1" is the first rising edge after an input change.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_botao_debounce;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pino2_raw = 1'b0;
    logic pino3_raw = 1'b0;
    logic pino2, pino3, press2, press3, pino13;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    botao_debounce #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pino2_raw(pino2_raw),
        .pino3_raw(pino3_raw),
        .pino2    (pino2),
        .pino3    (pino3),
        .press2   (press2),
        .press3   (press3),
        .pino13   (pino13)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        pino2_raw = 1'b0;
        pino3_raw = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
    endtask

    // Reset with both buttons held, then release reset: clean levels at edge
    // 6, press pulses only at edge 6, LED one edge later. Then release both.
    task automatic test_reset();
        logic [4:0] exp_v;
        @(negedge clk);
        rst_n     = 1'b0;
        pino2_raw = 1'b1;
        pino3_raw = 1'b1;
        #2;
        checks++;
        if ({pino2, pino3, press2, press3, pino13} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_async: outs=%b expected=00000", {pino2, pino3, press2, press3, pino13});
        end
        repeat (4) step();
        checks++;
        if ({pino2, pino3, press2, press3, pino13} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_held: outs=%b expected=00000", {pino2, pino3, press2, press3, pino13});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            exp_v = {(e >= 6) ? 1'b1 : 1'b0, (e >= 6) ? 1'b1 : 1'b0,
                     (e == 6) ? 1'b1 : 1'b0, (e == 6) ? 1'b1 : 1'b0,
                     (e >= 7) ? 1'b1 : 1'b0};
            checks++;
            if ({pino2, pino3, press2, press3, pino13} !== exp_v) begin
                errors++;
                $display("FAIL reset_release edge %0d: outs=%b expected=%b", e,
                         {pino2, pino3, press2, press3, pino13}, exp_v);
            end
        end
        // Release: clean levels fall at edge 6, never a press pulse.
        @(negedge clk);
        pino2_raw = 1'b0;
        pino3_raw = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
`ifdef BOTAO_DEBOUNCE_TOGGLE_EN
            exp_v = {(e < 6) ? 1'b1 : 1'b0, (e < 6) ? 1'b1 : 1'b0, 2'b00, 1'b1};
`else
            exp_v = {(e < 6) ? 1'b1 : 1'b0, (e < 6) ? 1'b1 : 1'b0, 2'b00,
                     (e < 7) ? 1'b1 : 1'b0};
`endif
            checks++;
            if ({pino2, pino3, press2, press3, pino13} !== exp_v) begin
                errors++;
                $display("FAIL release edge %0d: outs=%b expected=%b", e,
                         {pino2, pino3, press2, press3, pino13}, exp_v);
            end
        end
    endtask

    // Button 2 high for only 3 cycles: shorter than N, nothing may change.
    task automatic test_glitch();
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            pino3_raw = (e <= 3);
            step();
            checks++;
            if ({pino3, press3, pino13} !== 3'b000) begin
                errors++;
                $display("FAIL glitch edge %0d: pino3/press3/pino13=%b expected=000", e,
                         {pino3, press3, pino13});
            end
        end
    endtask

    // Button 1 bounces 1,0,1,0 then settles high at edge 5: pino2 must rise
    // on the 6th edge after settling (edge 10), with a single press pulse.
    task automatic test_bounce();
        int presses;
        logic [1:0] exp_v;
        presses = 0;
        do_reset();
        for (int e = 1; e <= 14; e++) begin
            @(negedge clk);
            pino2_raw = (e == 1) || (e == 3) || (e >= 5);
            step();
            if (press2 === 1'b1) presses++;
            exp_v = {(e >= 10) ? 1'b1 : 1'b0, (e == 10) ? 1'b1 : 1'b0};
            checks++;
            if ({pino2, press2} !== exp_v) begin
                errors++;
                $display("FAIL bounce edge %0d: pino2/press2=%b expected=%b", e, {pino2, press2}, exp_v);
            end
        end
        checks++;
        if (presses != 1) begin
            errors++;
            $display("FAIL bounce_press_count: got=%0d expected=1", presses);
        end
        @(negedge clk);
        pino2_raw = 1'b0;
        repeat (10) step();
    endtask

    task automatic set_and_check(input logic b2, input logic b3, input logic [2:0] exp_v,
                                 input string name);
        @(negedge clk);
        pino2_raw = b2;
        pino3_raw = b3;
        repeat (10) step();
        checks++;
        if ({pino2, pino3, pino13} !== exp_v) begin
            errors++;
            $display("FAIL %s: pino2/pino3/pino13=%b expected=%b", name, {pino2, pino3, pino13}, exp_v);
        end
    endtask

`ifdef BOTAO_DEBOUNCE_TOGGLE_EN
    // Two presses of button 1 toggle the LED on then off; a simultaneous
    // press of both buttons toggles it only once.
    task automatic test_toggle();
        do_reset();
        set_and_check(1'b0, 1'b0, 3'b000, "toggle_idle");
        set_and_check(1'b1, 1'b0, 3'b101, "toggle_press1");
        set_and_check(1'b0, 1'b0, 3'b001, "toggle_release1");
        set_and_check(1'b1, 1'b0, 3'b100, "toggle_press2");
        set_and_check(1'b0, 1'b0, 3'b000, "toggle_release2");
        set_and_check(1'b1, 1'b1, 3'b111, "toggle_both");
        set_and_check(1'b0, 1'b0, 3'b001, "toggle_both_release");
    endtask
`else
    // LED is the OR of the clean levels across the 00/10/11/01/00 sequence.
    task automatic test_or();
        do_reset();
        set_and_check(1'b0, 1'b0, 3'b000, "or_00");
        set_and_check(1'b1, 1'b0, 3'b101, "or_10");
        set_and_check(1'b1, 1'b1, 3'b111, "or_11");
        set_and_check(1'b0, 1'b1, 3'b011, "or_01");
        set_and_check(1'b0, 1'b0, 3'b000, "or_00_again");
    endtask
`endif

    // Reset in the middle of a button-1 debounce while button 2 is held
    // clean: everything drops at once, then both are re-accepted at edge 6.
    task automatic test_reset_mid();
        logic [3:0] exp_v;
        do_reset();
        set_and_check(1'b0, 1'b1, 3'b011, "mid_pre_b2");
        @(negedge clk);
        pino2_raw = 1'b1;
        repeat (4) step();
        checks++;
        if (pino2 !== 1'b0) begin
            errors++;
            $display("FAIL mid_waiting: pino2=%b expected=0", pino2);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pino2, pino3, press2, press3, pino13} !== 5'b00000) begin
            errors++;
            $display("FAIL mid_reset_async: outs=%b expected=00000", {pino2, pino3, press2, press3, pino13});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            exp_v = {(e >= 6) ? 1'b1 : 1'b0, (e >= 6) ? 1'b1 : 1'b0,
                     (e == 6) ? 1'b1 : 1'b0, (e == 6) ? 1'b1 : 1'b0};
            checks++;
            if ({pino2, pino3, press2, press3} !== exp_v) begin
                errors++;
                $display("FAIL mid_recover edge %0d: pino2/pino3/press2/press3=%b expected=%b", e,
                         {pino2, pino3, press2, press3}, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_bounce();
`ifdef BOTAO_DEBOUNCE_TOGGLE_EN
        test_toggle();
`else
        test_or();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_botao_debounce
